// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // ceil(w * log10(2)); the fixed-point constant rounds up, so this never under-counts
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    // Decimal one-hot of a BCD digit: bit k-1 set for k = 1..9, zero for 0
    function automatic logic [8:0] onehot9(input logic [3:0] d);
        logic [8:0] r;
        r = '0;
        if (d >= 4'd1 && d <= 4'd9) r[d - 4'd1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// One double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [NIBBLE-1:0] d_i,
    output logic [NIBBLE-1:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready on both sides, sticky overflow and a one-hot digit-0 decode.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_bin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIBBLE*DIGITS-1:0] out_bcd,
    output logic                     out_ovf,
    output logic [8:0]               out_onehot
);

    localparam int BW = NIBBLE * DIGITS;
    localparam int CW = $clog2(W + 1);
    // With enough digits nothing can ever leave the top digit, so the overflow path folds away
    localparam bit DIGITS_SHORT = (DIGITS < min_digits(W));

    state_e          state_q;
    logic [W-1:0]    sr_q;
    logic [BW-1:0]   acc_q;
    logic            work_ovf_q;
    logic [CW-1:0]   cnt_q;
    logic            valid_q;
    logic [BW-1:0]   bcd_q;
    logic            ovf_q;
    logic [8:0]      onehot_q;

    logic [BW-1:0]   adj;
    logic [BW-1:0]   acc_d;
    logic [W-1:0]    sr_d;
    logic            ovf_d;
    logic            last;
    logic            accept;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[g*NIBBLE +: NIBBLE]),
            .d_o (adj[g*NIBBLE +: NIBBLE])
        );
    end

    assign acc_d  = {adj[BW-2:0], sr_q[W-1]};
    assign sr_d   = {sr_q[W-2:0], 1'b0};
    assign ovf_d  = work_ovf_q | (DIGITS_SHORT && adj[BW-1]);
    assign last   = (cnt_q == CW'(W - 1));

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            work_ovf_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            onehot_q   <= '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    sr_q       <= sr_d;
                    acc_q      <= acc_d;
                    work_ovf_q <= ovf_d;
                    cnt_q      <= cnt_q + 1'b1;
                    if (last) begin
                        state_q  <= DONE;
                        valid_q  <= 1'b1;
                        bcd_q    <= acc_d;
                        ovf_q    <= ovf_d;
                        onehot_q <= onehot9(acc_d[NIBBLE-1:0]);
                    end
                end
                default: begin
                    if (state_q == DONE && out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                    // DONE with a waiting operand skips IDLE entirely
                    if (accept) begin
                        state_q    <= SHIFT;
                        sr_q       <= in_bin;
                        acc_q      <= '0;
                        work_ovf_q <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
            endcase
        end
    end

    assign out_valid  = valid_q;
    assign out_bcd    = bcd_q;
    assign out_ovf    = ovf_q;
    assign out_onehot = onehot_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: W=8 with 3 digits and with 2 digits (overflow).
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 3-digit instance
    logic        i3_valid, i3_ready, o3_valid, o3_ready, o3_ovf;
    logic [7:0]  i3_bin;
    logic [11:0] o3_bcd;
    logic [8:0]  o3_oh;

    // 2-digit instance
    logic        i2_valid, i2_ready, o2_valid, o2_ready, o2_ovf;
    logic [7:0]  i2_bin;
    logic [7:0]  o2_bcd;
    logic [8:0]  o2_oh;

    int total = 0;
    int bad   = 0;

    bin2bcd_seq #(.W(8), .DIGITS(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i3_valid), .in_ready(i3_ready), .in_bin(i3_bin),
        .out_valid(o3_valid), .out_ready(o3_ready),
        .out_bcd(o3_bcd), .out_ovf(o3_ovf), .out_onehot(o3_oh)
    );

    bin2bcd_seq #(.W(8), .DIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(i2_valid), .in_ready(i2_ready), .in_bin(i2_bin),
        .out_valid(o2_valid), .out_ready(o2_ready),
        .out_bcd(o2_bcd), .out_ovf(o2_ovf), .out_onehot(o2_oh)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept v on the next edge, then count cycles until out_valid (bounded).
    task automatic conv3(input logic [7:0] v, output int lat);
        i3_valid = 1'b1;
        i3_bin   = v;
        @(posedge clk); #1;
        i3_valid = 1'b0;
        i3_bin   = 8'hA5;   // later changes must be ignored
        lat = 0;
        while (!o3_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic conv2(input logic [7:0] v, output int lat);
        i2_valid = 1'b1;
        i2_bin   = v;
        @(posedge clk); #1;
        i2_valid = 1'b0;
        lat = 0;
        while (!o2_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [11:0] ref_bcd3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    initial begin
        int lat;
        int nxt;
        int got;
        int cyc;
        int q[$];

        rst_n = 1'b0;
        i3_valid = 1'b0; i3_bin = '0; o3_ready = 1'b1;
        i2_valid = 1'b0; i2_bin = '0; o2_ready = 1'b1;
        #1;
        chk("rst_out_valid", o3_valid, 0);
        chk("rst_out_bcd", o3_bcd, 0);
        chk("rst_out_ovf", o3_ovf, 0);
        chk("rst_onehot", o3_oh, 0);
        chk("rst_in_ready", i3_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 255 -> 12'h255, digit 0 is 5
        conv3(8'd255, lat);
        chk("lat_255", lat, 8);
        chk("bcd_255", o3_bcd, 12'h255);
        chk("ovf_255", o3_ovf, 0);
        chk("oh_255", o3_oh, 9'b0_0001_0000);

        conv3(8'd0, lat);
        chk("lat_0", lat, 8);
        chk("bcd_0", o3_bcd, 12'h000);
        chk("oh_0", o3_oh, 9'b0);
        conv3(8'd9, lat);
        chk("bcd_9", o3_bcd, 12'h009);
        chk("oh_9", o3_oh, 9'b1_0000_0000);

        // backpressure: hold 137 for 20 cycles
        @(posedge clk); #1;
        o3_ready = 1'b0;
        #1;
        conv3(8'd137, lat);
        chk("lat_137", lat, 8);
        for (int i = 0; i < 20; i++) begin
            chk("bp_bcd", o3_bcd, 12'h137);
            chk("bp_valid", o3_valid, 1);
            chk("bp_in_ready", i3_ready, 0);
            @(posedge clk); #1;
        end
        o3_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", i3_ready, 1);
        conv3(8'd42, lat);
        chk("lat_42", lat, 8);
        chk("bcd_42", o3_bcd, 12'h042);
        chk("oh_42", o3_oh, 9'b0_0000_0010);

        // two-digit instance: truncation plus overflow flag
        conv2(8'd199, lat);
        chk("lat_199_d2", lat, 8);
        chk("bcd_199_d2", o2_bcd, 8'h99);
        chk("ovf_199_d2", o2_ovf, 1);
        conv2(8'd99, lat);
        chk("bcd_99_d2", o2_bcd, 8'h99);
        chk("ovf_99_d2", o2_ovf, 0);
        conv2(8'd100, lat);
        chk("bcd_100_d2", o2_bcd, 8'h00);
        chk("ovf_100_d2", o2_ovf, 1);
        chk("oh_100_d2", o2_oh, 9'b0);

        // reset mid-conversion
        @(posedge clk); #1;
        i3_valid = 1'b1; i3_bin = 8'd200;
        @(posedge clk); #1;
        i3_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", o3_valid, 0);
        chk("midrst_bcd", o3_bcd, 0);
        chk("midrst_oh", o3_oh, 0);
        chk("midrst_in_ready", i3_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", o3_valid, 0);
        end
        conv3(8'd64, lat);
        chk("lat_64", lat, 8);
        chk("bcd_64", o3_bcd, 12'h064);
        @(posedge clk); #1;

        // exhaustive sweep with random out_ready gaps
        nxt = 0; got = 0; cyc = 0;
        while (got < 256 && cyc < 6000) begin
            o3_ready = 1'($urandom_range(0, 1));
            i3_valid = (nxt < 256);
            i3_bin   = 8'(nxt);
            #1;
            if (o3_valid && o3_ready) begin
                if (q.size() == 0) begin
                    chk("sweep_spurious_result", 1, 0);
                end else begin
                    chk("sweep_bcd", o3_bcd, ref_bcd3(q[0]));
                    chk("sweep_ovf", o3_ovf, 0);
                    void'(q.pop_front());
                end
                got++;
            end
            if (i3_valid && i3_ready) begin
                q.push_back(nxt);
                nxt++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i3_valid = 1'b0;
        chk("sweep_count", got, 256);
        chk("sweep_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

- Parametrised, sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Successor to the combinational 4-bit binary-to-decimal decoder: generalised to W-bit input and DIGITS BCD digits, with a valid/ready handshake on both sides and overflow detection.
- Keeps a one-hot decimal decode of the least-significant digit, the same b1..b9 style as the old decoder, so existing display logic can attach unchanged.
- Sits between a binary counter/ALU result and the 7-segment/LED display drivers.

## Interface
Parameters:
- W, 8, binary input width (≥ 2)
- DIGITS, 3, number of BCD output digits (≥ 1)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_bin is valid
- in_ready  output  1  converter can accept a value
- in_bin  input  W  unsigned binary operand
- out_valid  output  1  result is valid; held until accepted
- out_ready  input  1  downstream accepts result
- out_bcd  output  4*DIGITS  packed BCD; digit 0 = bits [3:0]
- out_ovf  output  1  in_bin > 10^DIGITS − 1
- out_onehot  output  9  bit k−1 set iff digit 0 == k (k = 1..9); all zero for digit 0

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load shift register ← in_bin, BCD accumulator ← 0, ovf ← 0, bit counter ← 0, go to SHIFT.
- SHIFT, each cycle:
  - Every digit ≥ 5 gets +3.
  - Shift {accumulator, shift register} left by 1.
  - A 1 shifted out of the top digit sets the sticky ovf.
  - Counter increments; after the W-th shift, go to DONE.
- DONE:
  - out_valid = 1; out_bcd, out_ovf and out_onehot are stable.
  - On out_ready: drop out_valid.
  - If in_valid is also high in that same cycle, load the new operand and go straight to SHIFT; otherwise go to IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational from state and out_ready only; no path from in_valid.
- Overflow: out_bcd = in_bin mod 10^DIGITS (low digits after truncation), out_ovf = 1.
- out_onehot is decoded from the registered digit 0. A digit 0 value of 10–15 cannot occur.
- in_bin is sampled only on the accept edge; later changes are ignored.

## Timing
- Reset (rst_n low, asynchronous):
  - State → IDLE.
  - out_valid = 0, out_bcd = 0, out_ovf = 0, out_onehot = 0.
  - in_ready = 1 (IDLE).
- Reset mid-SHIFT or in DONE: the result is discarded; no out_valid pulse after release.
- Latency: operand accepted at edge E → out_valid high from edge E+W onward (W SHIFT cycles).
- Throughput with out_ready tied high: one result every W+1 cycles (DONE→SHIFT directly).
- Backpressure: with out_ready low, DONE holds indefinitely, in_ready = 0, and outputs are held bit-stable.
- in_valid high while in SHIFT: not accepted; the source must hold it.

## Structure
- Package bin2bcd_pkg:
  - state typedef (IDLE, SHIFT, DONE).
  - NIBBLE = 4.
  - Function min_digits(W) = ceil(W·log10 2), used for an elaboration-time warning if DIGITS is smaller. This is a warning, not an error; overflow is legal.
- Sub-module bcd_digit_adj: combinational, 4-bit in → 4-bit out, adds 3 when ≥ 5. Instantiated DIGITS times with a generate loop.
- Counter width: $clog2(W+1).

## Test plan
- W=8, DIGITS=3, in_bin = 255, out_ready = 1:
  - out_valid rises exactly 8 cycles after accept.
  - out_bcd = 12'h255, out_ovf = 0, out_onehot = 9'b0_0001_0000 (digit 5).
- in_bin = 0: out_bcd = 12'h000, out_onehot = 0. Then in_bin = 9: out_onehot = 9'b1_0000_0000.
- Backpressure: out_ready low for 20 cycles after a conversion of 137:
  - out_bcd = 12'h137 held throughout, in_ready = 0.
  - Raise out_ready with in_valid high and in_bin = 42: next result 12'h042 arrives W cycles after that edge.
- W=8, DIGITS=2, in_bin = 199 → out_bcd = 8'h99, out_ovf = 1. in_bin = 99 → 8'h99, out_ovf = 0.
- Reset asserted at cycle 4 of SHIFT:
  - All outputs go to 0 immediately, in_ready = 1.
  - After release, a new conversion of 64 gives 12'h064.
- Exhaustive sweep of 0..2^W−1 with random out_ready gaps: every result checked against a reference model, none lost, none duplicated.
